// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler: queues convolution jobs, launches them one at a time and checks each job's output count
// Ports:
//   clk, arst_n_in                     clock, asynchronous active-low reset
//   job_valid/job_ready                host job handshake
//   job_base_addr, job_nb_outputs      job payload (base address, expected output count)
//   ctrl_start, ctrl_base_addr         launch pulse and base address to the convolution controller
//   ctrl_running, ctrl_output_valid    controller busy level and output strobe
//   busy, job_done, job_id             scheduler status, completion pulse, last completed job number
//   out_count, error, clear_error      output counter, sticky count-mismatch flag and its clear
module conv_job_scheduler #(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int QUEUE_DEPTH        = 4,
    parameter int DRAIN_CYCLES       = 4
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [LOG2_OF_MEM_HEIGHT-1:0] job_base_addr,
    input  logic [31:0]                   job_nb_outputs,
    output logic                          ctrl_start,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] ctrl_base_addr,
    input  logic                          ctrl_running,
    input  logic                          ctrl_output_valid,
    output logic                          busy,
    output logic                          job_done,
    output logic [7:0]                    job_id,
    output logic [31:0]                   out_count,
    output logic                          error,
    input  logic                          clear_error
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_RUN, RUN, DRAIN, DONE} state_t;

    state_t                        state, state_nxt;
    logic [LOG2_OF_MEM_HEIGHT-1:0] q_addr [QUEUE_DEPTH];
    logic [31:0]                   q_nb   [QUEUE_DEPTH];
    logic [PW-1:0]                 rd_ptr, wr_ptr;
    logic [PW:0]                   occ;
    logic [31:0]                   exp_count;
    logic [DW-1:0]                 drain_cnt;
    logic                          push, pop, counting;

    // ready depends only on the registered occupancy, so a same-cycle pop never admits a push into a full queue
    assign job_ready  = occ != (PW+1)'(QUEUE_DEPTH);
    assign push       = job_valid && job_ready;
    assign pop        = state == LAUNCH;
    assign counting   = ctrl_output_valid && (state == WAIT_RUN || state == RUN || state == DRAIN);
    assign ctrl_start = pop;
    assign busy       = state != IDLE;
    assign job_done   = state == DONE;

    always_ff @(posedge clk)
        if (push) begin
            q_addr[wr_ptr] <= job_base_addr;
            q_nb[wr_ptr]   <= job_nb_outputs;
        end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = occ != '0 ? LAUNCH : IDLE;
            LAUNCH:   state_nxt = WAIT_RUN;
            WAIT_RUN: state_nxt = ctrl_running ? RUN : WAIT_RUN;
            RUN:      state_nxt = ctrl_running ? RUN : DRAIN;
            DRAIN:    state_nxt = drain_cnt == DW'(1) ? DONE : DRAIN;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            occ            <= '0;
            ctrl_base_addr <= '0;
            exp_count      <= '0;
            drain_cnt      <= '0;
            job_id         <= '0;
            out_count      <= '0;
            error          <= 1'b0;
        end else begin
            state  <= state_nxt;
            occ    <= occ + (PW+1)'(push) - (PW+1)'(pop);
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            // capture the head on the way into LAUNCH so the address is already valid alongside ctrl_start
            if (state == IDLE && occ != '0) begin
                ctrl_base_addr <= q_addr[rd_ptr];
                exp_count      <= q_nb[rd_ptr];
            end
            out_count <= pop ? '0 : (counting && out_count != '1) ? out_count + 32'd1 : out_count;
            drain_cnt <= state == RUN ? DW'(DRAIN_CYCLES) : state == DRAIN ? drain_cnt - DW'(1) : drain_cnt;
            job_id    <= job_id + 8'(job_done);
            // a mismatch at completion wins over a simultaneous clear
            error     <= (job_done && out_count != exp_count) || (error && !clear_error);
        end
    end
endmodule

// File: tb/tb_conv_job_scheduler.sv
// tb_conv_job_scheduler: randomized scoreboard bench for conv_job_scheduler
module tb_conv_job_scheduler;
    localparam int AW = 20;
    localparam int QD = 4;
    localparam int DC = 4;

    logic          clk = 0, arst_n_in = 0, job_valid = 0, job_ready;
    logic [AW-1:0] job_base_addr = '0, ctrl_base_addr;
    logic [31:0]   job_nb_outputs = '0, out_count;
    logic          ctrl_start, ctrl_running = 0, ctrl_output_valid = 0;
    logic          busy, job_done, error, clear_error = 0;
    logic [7:0]    job_id;

    conv_job_scheduler #(.LOG2_OF_MEM_HEIGHT(AW), .QUEUE_DEPTH(QD), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .job_valid(job_valid), .job_ready(job_ready),
        .job_base_addr(job_base_addr), .job_nb_outputs(job_nb_outputs), .ctrl_start(ctrl_start),
        .ctrl_base_addr(ctrl_base_addr), .ctrl_running(ctrl_running), .ctrl_output_valid(ctrl_output_valid),
        .busy(busy), .job_done(job_done), .job_id(job_id), .out_count(out_count), .error(error),
        .clear_error(clear_error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] base; logic [31:0] nb; } job_t;
    typedef struct { logic [7:0] id; logic [AW-1:0] base; logic [31:0] cnt; bit mis; } done_t;
    // controller behaviour for one job: idle w cycles after start, running r cycles, strobe where mask bit k is set
    // (k = cycles since the launch cycle)
    typedef struct { int w; int r; logic [63:0] mask; bit clr; } plan_t;

    job_t  lq[$];
    job_t  host_q[$];
    done_t dq[$];
    plan_t plan_q[$];
    int    errors = 0, checks = 0, n_done = 0, n_start = 0;
    bit    host_rand = 0, rand_clr = 0, man_clr = 0;
    logic [7:0] model_id = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // stimulus: host pushes and a behavioural convolution controller
    initial begin : driver
        job_t  j;
        plan_t cur;
        int    k, done_k, occ, c;
        bit    act;
        act = 0; k = 0; done_k = 0; cur = '{0, 1, '0, 1'b0};
        forever begin
            @(negedge clk);
            if (!arst_n_in) begin
                act = 0; model_id = 0;
                lq.delete(); host_q.delete(); plan_q.delete();
                job_valid = 0; ctrl_running = 0; ctrl_output_valid = 0; clear_error = 0;
                continue;
            end
            occ = lq.size();
            chk("job_ready", job_ready, occ < QD);
            if (act) begin
                k++;
                if (k == done_k) chk("job_done_timing", job_done, 1);
                if (k > done_k) act = 0;
            end
            if (ctrl_start) begin
                n_start++;
                chk("start_only_after_done", act, 0);
                chk("start_queue_nonempty", occ != 0, 1);
                if (occ != 0) begin
                    j = lq.pop_front();
                    if (plan_q.size() != 0) cur = plan_q.pop_front();
                    else cur = '{int'($urandom_range(0, 5)), int'($urandom_range(1, 20)), {$urandom, $urandom}, 1'b0};
                    // outputs count from the cycle after launch until DC cycles after running is seen low
                    c = 0;
                    for (int i = 1; i <= cur.w + cur.r + 1 + DC; i++) c += int'(cur.mask[i]);
                    model_id++;
                    dq.push_back('{model_id, j.base, 32'(c), 32'(c) != j.nb});
                    chk("ctrl_base_addr_at_start", ctrl_base_addr, j.base);
                    act = 1; k = 0; done_k = cur.w + cur.r + 2 + DC;
                end
            end
            ctrl_running      = act && k >= cur.w + 1 && k <= cur.w + cur.r;
            ctrl_output_valid = act ? cur.mask[k] : 1'($urandom_range(0, 1));
            clear_error       = man_clr || (act && k == done_k && cur.clr) || (rand_clr && $urandom_range(0, 19) == 0);
            job_valid = 0;
            if (host_q.size() != 0 || (host_rand && $urandom_range(0, 99) < 30)) begin
                if (host_q.size() != 0) j = host_q[0];
                else j = '{AW'($urandom), 32'($urandom_range(0, 20))};
                job_valid = 1; job_base_addr = j.base; job_nb_outputs = j.nb;
                if (occ < QD) begin
                    lq.push_back(j);
                    if (host_q.size() != 0) host_q.delete(0);
                end
            end
        end
    end

    // monitor: pops the scoreboard on every job_done and tracks the sticky error flag
    initial begin : monitor
        done_t r;
        bit    pend, got;
        logic  eerr;
        pend = 0; eerr = 0; r = '{0, '0, '0, 1'b0};
        forever begin
            @(negedge clk); #1;
            if (!arst_n_in) begin
                dq.delete(); pend = 0; eerr = 0;
                continue;
            end
            if (pend) begin
                chk("job_id", job_id, r.id);
                chk("out_count", out_count, r.cnt);
                pend = 0;
            end
            chk("error", error, eerr);
            got = 0;
            if (job_done) begin
                n_done++;
                if (dq.size() == 0) chk("job_done_unexpected", job_done, 0);
                else begin
                    r = dq.pop_front();
                    got = 1; pend = 1;
                    chk("ctrl_base_addr_at_done", ctrl_base_addr, r.base);
                end
            end
            eerr = (got && r.mis) || (eerr && !clear_error);
        end
    end

    task automatic wait_done(input int target, input int limit);
        int n = 0;
        while (n_done < target && n < limit) begin @(posedge clk); n++; end
        chk("done_count", n_done, target);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_job_ready", job_ready, 1);
        chk("rst_ctrl_start", ctrl_start, 0);
        chk("rst_ctrl_base_addr", ctrl_base_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_job_done", job_done, 0);
        chk("rst_job_id", job_id, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_error", error, 0);
    endtask

    initial begin : main
        int n, base;
        #1 check_reset_values();
        repeat (3) @(posedge clk);
        #2 arst_n_in = 1;

        // single job: 8 strobes while running
        @(posedge clk);
        plan_q.push_back('{1, 20, 64'h7F8, 1'b0});
        host_q.push_back('{20'h100, 32'd8});
        wait_done(1, 200);
        chk("single_start_pulses", n_start, 1);
        chk("single_job_id", job_id, 1);
        chk("single_out_count", out_count, 8);
        chk("single_error", error, 0);

        // late strobes inside the drain window count, one after it does not
        plan_q.push_back('{0, 5, 64'hB00, 1'b0});
        host_q.push_back('{20'h2A5, 32'd2});
        wait_done(2, 200);
        chk("late_out_count", out_count, 2);
        chk("late_error", error, 0);

        // mismatch, then a clear coinciding with a second mismatching completion
        plan_q.push_back('{0, 3, 64'h1E, 1'b0});
        host_q.push_back('{20'h33, 32'd5});
        plan_q.push_back('{0, 3, 64'h1E, 1'b1});
        host_q.push_back('{20'h44, 32'd5});
        wait_done(4, 300);
        chk("mismatch_error_sticky", error, 1);
        chk("mismatch_job_id", job_id, 4);
        @(posedge clk) man_clr = 1;
        @(posedge clk) man_clr = 0;
        @(negedge clk); #2;
        chk("error_cleared", error, 0);

        // burst of jobs behind a long run fills the queue
        @(posedge clk);
        plan_q.push_back('{2, 30, {$urandom, $urandom}, 1'b0});
        for (int i = 0; i < 6; i++) host_q.push_back('{AW'(20'h1000 + i), 32'($urandom_range(0, 20))});
        wait_done(10, 1500);
        chk("burst_job_id", job_id, 10);

        // random traffic
        host_rand = 1; rand_clr = 1;
        wait_done(40, 8000);
        host_rand = 0;
        n = 0;
        while ((busy || lq.size() != 0) && n < 3000) begin @(posedge clk); n++; end
        rand_clr = 0;
        chk("random_drained", busy, 0);
        repeat (3) @(posedge clk);

        // reset during RUN with two jobs still queued
        base = n_done;
        plan_q.push_back('{0, 40, {$urandom, $urandom}, 1'b0});
        for (int i = 0; i < 3; i++) host_q.push_back('{AW'(20'h5000 + i), 32'd3});
        n = 0;
        while (!ctrl_running && n < 200) begin @(posedge clk); n++; end
        repeat (5) @(posedge clk);
        chk("reached_run_busy", busy, 1);
        #2 arst_n_in = 0;
        #1 check_reset_values();
        repeat (3) @(posedge clk);
        #2 arst_n_in = 1;
        repeat (20) @(posedge clk);
        chk("no_done_after_reset", n_done, base);
        #1;
        chk("post_reset_ready", job_ready, 1);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_job_id", job_id, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
